// File: rtl/rat_alu_pkg.sv
// Shared types for the RAT ALU: operation codes and datapath width.
package rat_alu_pkg;

    localparam int RAT_WIDTH = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADDC = 4'd1,
        OP_SUB  = 4'd2,
        OP_SUBC = 4'd3,
        OP_CMP  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_EXOR = 4'd7,
        OP_TEST = 4'd8,
        OP_LSL  = 4'd9,
        OP_LSR  = 4'd10,
        OP_ROL  = 4'd11,
        OP_ROR  = 4'd12,
        OP_ASR  = 4'd13,
        OP_MOV  = 4'd14,
        OP_RSVD = 4'd15
    } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// Combinational RAT ALU: result, next carry and zero from A, B, SEL, cin.
module alu_core
    import rat_alu_pkg::*;
#(
    parameter int WIDTH = RAT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             z_out
);

    alu_op_t        op;
    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [WIDTH:0] ext_c;
    logic [WIDTH:0] wide;

    assign op    = alu_op_t'(sel);
    assign ext_a = {1'b0, a};
    assign ext_b = {1'b0, b};
    assign ext_c = {{WIDTH{1'b0}}, cin};

    // Subtraction wraps in WIDTH+1 bits, so the top bit is the borrow.
    always_comb begin
        wide   = '0;
        result = '0;
        c_out  = 1'b0;
        case (op)
            OP_ADD: wide = ext_a + ext_b;
            OP_ADDC: wide = ext_a + ext_b + ext_c;
            OP_SUB, OP_CMP: wide = ext_a - ext_b;
            OP_SUBC: wide = ext_a - ext_b - ext_c;
            OP_AND, OP_TEST: wide = {1'b0, a & b};
            OP_OR: wide = {1'b0, a | b};
            OP_EXOR: wide = {1'b0, a ^ b};
            OP_LSL: wide = {a, cin};
            OP_LSR: wide = {a[0], cin, a[WIDTH-1:1]};
            OP_ROL: wide = {a, a[WIDTH-1]};
            OP_ROR: wide = {a[0], a[0], a[WIDTH-1:1]};
            OP_ASR: wide = {a[0], a[WIDTH-1], a[WIDTH-1:1]};
            OP_MOV: wide = {cin, b};
            default: wide = '0;
        endcase
        result = wide[WIDTH-1:0];
        c_out  = wide[WIDTH];
    end

    assign z_out = (result == '0);

endmodule

// File: rtl/alu_flags.sv
// RAT ALU with registered carry/zero flags and interrupt shadow copies.
module alu_flags
    import rat_alu_pkg::*;
#(
    parameter int WIDTH = RAT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       SEL,
    input  logic             FLG_C_LD,
    input  logic             FLG_Z_LD,
    input  logic             FLG_C_SET,
    input  logic             FLG_C_CLR,
    input  logic             FLG_LD_SEL,
    input  logic             FLG_SHAD_LD,
    output logic [WIDTH-1:0] RESULT,
    output logic             C_FLAG,
    output logic             Z_FLAG,
    output logic             SHAD_C,
    output logic             SHAD_Z
);

    logic c_q, c_d;
    logic z_q, z_d;
    logic shad_c_q, shad_c_d;
    logic shad_z_q, shad_z_d;
    logic c_out, z_out;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a     (A),
        .b     (B),
        .sel   (SEL),
        .cin   (c_q),
        .result(RESULT),
        .c_out (c_out),
        .z_out (z_out)
    );

    // Shadow load and restore on one edge swap live and shadow flags.
    always_comb begin
        c_d      = c_q;
        z_d      = z_q;
        shad_c_d = shad_c_q;
        shad_z_d = shad_z_q;
        if (FLG_C_CLR) begin
            c_d = 1'b0;
        end else if (FLG_C_SET) begin
            c_d = 1'b1;
        end else if (FLG_C_LD) begin
            c_d = FLG_LD_SEL ? shad_c_q : c_out;
        end
        if (FLG_Z_LD) begin
            z_d = FLG_LD_SEL ? shad_z_q : z_out;
        end
        if (FLG_SHAD_LD) begin
            shad_c_d = c_q;
            shad_z_d = z_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            shad_c_q <= 1'b0;
            shad_z_q <= 1'b0;
        end else begin
            c_q      <= c_d;
            z_q      <= z_d;
            shad_c_q <= shad_c_d;
            shad_z_q <= shad_z_d;
        end
    end

    assign C_FLAG = c_q;
    assign Z_FLAG = z_q;
    assign SHAD_C = shad_c_q;
    assign SHAD_Z = shad_z_q;

endmodule

// File: tb/tb_alu_flags.sv
// Randomized self-checking bench for alu_flags against an arithmetic model.
module tb_alu_flags;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic [3:0] SEL = '0;
    logic       FLG_C_LD = 0, FLG_Z_LD = 0;
    logic       FLG_C_SET = 0, FLG_C_CLR = 0;
    logic       FLG_LD_SEL = 0, FLG_SHAD_LD = 0;
    logic [7:0] RESULT;
    logic       C_FLAG, Z_FLAG, SHAD_C, SHAD_Z;

    int total = 0;
    int bad = 0;

    bit mc = 0, mz = 0, msc = 0, msz = 0;

    alu_flags dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .A          (A),
        .B          (B),
        .SEL        (SEL),
        .FLG_C_LD   (FLG_C_LD),
        .FLG_Z_LD   (FLG_Z_LD),
        .FLG_C_SET  (FLG_C_SET),
        .FLG_C_CLR  (FLG_C_CLR),
        .FLG_LD_SEL (FLG_LD_SEL),
        .FLG_SHAD_LD(FLG_SHAD_LD),
        .RESULT     (RESULT),
        .C_FLAG     (C_FLAG),
        .Z_FLAG     (Z_FLAG),
        .SHAD_C     (SHAD_C),
        .SHAD_Z     (SHAD_Z)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: returns {carry, result} computed with integer arithmetic.
    function automatic int model(input int s, input int a, input int b,
                                 input int ci);
        int r, co;
        r = 0;
        co = 0;
        case (s)
            0: begin r = a + b; co = (r > 255); end
            1: begin r = a + b + ci; co = (r > 255); end
            2, 4: begin r = a - b; co = (a < b); end
            3: begin r = a - b - ci; co = (a < b + ci); end
            5, 8: r = a & b;
            6: r = a | b;
            7: r = a ^ b;
            9: begin r = a * 2 + ci; co = (a >= 128); end
            10: begin r = a / 2 + ci * 128; co = a % 2; end
            11: begin r = a * 2 + a / 128; co = (a >= 128); end
            12: begin r = a / 2 + (a % 2) * 128; co = a % 2; end
            13: begin r = a / 2 + ((a >= 128) ? 128 : 0); co = a % 2; end
            14: begin r = b; co = ci; end
            default: begin r = 0; co = 0; end
        endcase
        r = ((r % 256) + 256) % 256;
        return co * 256 + r;
    endfunction

    task automatic check_flags(input string tag);
        chk({tag, "_c"}, int'(C_FLAG), int'(mc));
        chk({tag, "_z"}, int'(Z_FLAG), int'(mz));
        chk({tag, "_sc"}, int'(SHAD_C), int'(msc));
        chk({tag, "_sz"}, int'(SHAD_Z), int'(msz));
    endtask

    // Called just after a rising edge; leaves time just after the next one.
    task automatic step(input string tag, input int s, input int a,
                        input int b, input bit cld, input bit zld,
                        input bit cset, input bit cclr, input bit lsel,
                        input bit shld);
        int m, er;
        bit eco, ezo, nc, nz, nsc, nsz;
        SEL = 4'(s);
        A = 8'(a);
        B = 8'(b);
        FLG_C_LD = cld;
        FLG_Z_LD = zld;
        FLG_C_SET = cset;
        FLG_C_CLR = cclr;
        FLG_LD_SEL = lsel;
        FLG_SHAD_LD = shld;
        m = model(s, a, b, int'(mc));
        er = m % 256;
        eco = (m >= 256);
        ezo = (er == 0);
        #2;
        chk({tag, "_res"}, int'(RESULT), er);
        nc = cclr ? 1'b0 : cset ? 1'b1 : cld ? (lsel ? msc : eco) : mc;
        nz = zld ? (lsel ? msz : ezo) : mz;
        nsc = shld ? mc : msc;
        nsz = shld ? mz : msz;
        @(posedge CLK);
        #1;
        mc = nc;
        mz = nz;
        msc = nsc;
        msz = nsz;
        check_flags(tag);
        FLG_C_LD = 0;
        FLG_Z_LD = 0;
        FLG_C_SET = 0;
        FLG_C_CLR = 0;
        FLG_LD_SEL = 0;
        FLG_SHAD_LD = 0;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check_flags("reset");
        RST_N = 1'b1;

        step("add_ff", 0, 8'hFF, 8'h01, 1, 1, 0, 0, 0, 0);
        chk("add_c1", int'(C_FLAG), 1);
        chk("add_z1", int'(Z_FLAG), 1);
        step("addc", 1, 8'h01, 8'h01, 1, 1, 0, 0, 0, 0);
        step("setc", 14, 0, 0, 0, 0, 1, 0, 0, 0);
        step("subc", 3, 8'h10, 8'h05, 1, 1, 0, 0, 0, 0);
        step("sub_borrow", 2, 8'h00, 8'h01, 1, 1, 0, 0, 0, 0);
        chk("sub_borrow_c", int'(C_FLAG), 1);
        step("lsr", 10, 8'h01, 0, 1, 1, 0, 0, 0, 0);
        step("asr", 13, 8'h80, 0, 1, 1, 0, 0, 0, 0);
        step("ror", 12, 8'h01, 0, 1, 1, 0, 0, 0, 0);
        step("set_clr", 0, 8'hFF, 8'h01, 1, 0, 1, 1, 0, 0);
        chk("set_clr_c0", int'(C_FLAG), 0);
        step("c1z0", 14, 0, 8'h33, 0, 1, 1, 0, 0, 0);
        step("shad_ld", 14, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("shad_c1", int'(SHAD_C), 1);
        step("clr", 14, 0, 0, 0, 0, 0, 1, 0, 0);
        step("restore", 14, 0, 0, 1, 1, 0, 0, 1, 0);
        chk("restore_c1", int'(C_FLAG), 1);
        step("swap", 0, 0, 0, 1, 1, 1, 1, 1, 1);

        step("all1a", 0, 8'hFF, 8'h01, 1, 1, 0, 0, 0, 0);
        step("all1b", 14, 0, 0, 0, 0, 0, 0, 0, 1);
        SEL = 4'd1;
        A = 8'h01;
        B = 8'h01;
        #2;
        RST_N = 1'b0;
        mc = 0;
        mz = 0;
        msc = 0;
        msz = 0;
        #1;
        check_flags("async_rst");
        chk("rst_res", int'(RESULT), 2);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        step("mov0", 14, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        chk("mov0_z1", int'(Z_FLAG), 1);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            step("rnd", int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 r == 0, r == 1 || r == 2, r < 4, r >= 13);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
